// File: rtl/event_pulse_scheduler.sv
// event_pulse_scheduler: per-channel level-change counting with round-robin
// serialisation into spaced, channel-tagged single-cycle pulses.
module event_pulse_scheduler #(
   parameter  int unsigned N_CH  = 4,
   parameter  int unsigned CNT_W = 4,
   parameter  int unsigned GAP   = 3,
   localparam int unsigned IDX_W = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  lvl,
   input  logic             dst_ready,
   output logic             out_pulse,
   output logic [IDX_W-1:0] out_ch,
   output logic             pending_any,
   output logic [N_CH-1:0]  overflow
);

   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP_S = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [GAP_W-1:0]   gcnt_q, gcnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   cnt_q [N_CH];
   logic [CNT_W-1:0]   cnt_d [N_CH];
   logic [N_CH-1:0]    lvl_q, lvl_d;
   logic [N_CH-1:0]    ovf_q, ovf_d;
   logic               out_pulse_q, out_pulse_d;
   logic [IDX_W-1:0]   out_ch_q, out_ch_d;
   logic               pend_q, pend_d;

   logic [N_CH-1:0]    evt;
   logic               any_cnt;
   logic               found;
   logic [IDX_W-1:0]   gnt_idx;
   logic               grant;

   // Any transition on a level input is one event.
   always_comb begin
      lvl_d = lvl;
      evt   = lvl ^ lvl_q;
   end

   // Round-robin pick: first non-empty channel after the last one granted.
   always_comb begin
      any_cnt = 1'b0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         logic [IDX_W-1:0] idx;
         idx = IDX_W'((32'(last_q) + k) % N_CH);
         if (cnt_q[idx] != '0) begin
            any_cnt = 1'b1;
            if (!found) begin
               found   = 1'b1;
               gnt_idx = idx;
            end
         end
      end
   end

   // FSM next state, grant, counter update and registered-output next values.
   always_comb begin
      state_d     = state_q;
      gcnt_d      = gcnt_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_pulse_d = 1'b0;
      out_ch_d    = '0;
      grant       = 1'b0;
      pend_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_cnt && dst_ready) grant = 1'b1;
         end
         PULSE: begin
            state_d = GAP_S;
            gcnt_d  = GAP_W'(GAP - 1);
         end
         GAP_S: begin
            if (gcnt_q != '0) begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end else if (any_cnt && dst_ready) begin
               grant = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         state_d     = PULSE;
         last_d      = gnt_idx;
         out_pulse_d = 1'b1;
         out_ch_d    = gnt_idx;
      end

      // Increment on event, decrement on grant; both at once cancel out.
      for (int unsigned i = 0; i < N_CH; i++) begin
         logic dec;
         dec = grant && (gnt_idx == IDX_W'(i));
         if (evt[i] && !dec) begin
            if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec && !evt[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         if (cnt_d[i] != '0) pend_d = 1'b1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gcnt_q      <= '0;
         last_q      <= IDX_W'(N_CH - 1);
         lvl_q       <= '0;
         ovf_q       <= '0;
         out_pulse_q <= 1'b0;
         out_ch_q    <= '0;
         pend_q      <= 1'b0;
         for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         gcnt_q      <= gcnt_d;
         last_q      <= last_d;
         lvl_q       <= lvl_d;
         ovf_q       <= ovf_d;
         out_pulse_q <= out_pulse_d;
         out_ch_q    <= out_ch_d;
         pend_q      <= pend_d;
         for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign out_pulse   = out_pulse_q;
   assign out_ch      = out_ch_q;
   assign pending_any = pend_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_event_pulse_scheduler.sv
// Self-checking bench for event_pulse_scheduler (N_CH=4, CNT_W=4, GAP=3).
module tb_event_pulse_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] lvl;
   logic       dst_ready;
   logic       out_pulse;
   logic [1:0] out_ch;
   logic       pending_any;
   logic [3:0] overflow;

   int n_tests = 0;
   int n_fail  = 0;

   event_pulse_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .lvl         (lvl),
      .dst_ready   (dst_ready),
      .out_pulse   (out_pulse),
      .out_ch      (out_ch),
      .pending_any (pending_any),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] lvl;
      logic       rdy;
      logic       pulse;
      logic [1:0] ch;
      logic       pend;
      logic [3:0] ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [3:0] l, input logic d,
                               input logic p, input logic [1:0] c, input logic pe,
                               input logic [3:0] o);
      vec_t v;
      v.rst = r; v.lvl = l; v.rdy = d; v.pulse = p; v.ch = c; v.pend = pe; v.ovf = o;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int cnt_p, low, seen;
      int chs[16];

      reset = 1'b1; lvl = '0; dst_ready = 1'b1;

      // Single event on ch 2, then all four channels at once after reset.
      vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 4'b0100, 1, 1, 2, 0, 4'b0000));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 1, 4'b0000));
      for (int c = 0; c < 4; c++) begin
         vecs.push_back(mk(0, 4'b1111, 1, 1, 2'(c), (c < 3) ? 1'b1 : 1'b0, 4'b0000));
         if (c < 3)
            for (int g = 0; g < 3; g++) vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 1, 4'b0000));
      end
      vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 4'b0000));

      foreach (vecs[i]) begin
         reset = vecs[i].rst; lvl = vecs[i].lvl; dst_ready = vecs[i].rdy;
         tick();
         check($sformatf("vec%0d.pulse", i), 32'(out_pulse),   32'(vecs[i].pulse));
         check($sformatf("vec%0d.ch", i),    32'(out_ch),      32'(vecs[i].ch));
         check($sformatf("vec%0d.pend", i),  32'(pending_any), 32'(vecs[i].pend));
         check($sformatf("vec%0d.ovf", i),   32'(overflow),    32'(vecs[i].ovf));
      end

      // Saturation: 20 toggles on ch 1 with downstream not ready.
      lvl = '0; dst_ready = 1'b0;
      do_reset();
      for (int t = 0; t < 20; t++) begin
         lvl[1] = ~lvl[1];
         tick();
         check("sat.no_pulse", 32'(out_pulse), 0);
      end
      check("sat.ovf", 32'(overflow), 32'h2);
      check("sat.pend", 32'(pending_any), 1);
      dst_ready = 1'b1;
      cnt_p = 0; low = 0; seen = 0;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (out_pulse) begin
            check("sat.ch", 32'(out_ch), 1);
            if (seen != 0) check("sat.gap", 32'(low), 3);
            seen = 1; low = 0; cnt_p++;
         end else begin
            low++;
         end
      end
      check("sat.count", 32'(cnt_p), 15);
      check("sat.ovf_sticky", 32'(overflow), 32'h2);
      check("sat.pend_fall", 32'(pending_any), 0);

      // Reset during a pulse with events pending; lvl stays high through release.
      lvl = 4'b1111;
      tick();
      check("rst.pend_pre", 32'(pending_any), 1);
      tick();
      check("rst.pulse_pre", 32'(out_pulse), 1);
      check("rst.ch_pre", 32'(out_ch), 2);
      reset = 1'b1;
      tick();
      check("rst.pulse", 32'(out_pulse), 0);
      check("rst.ch", 32'(out_ch), 0);
      check("rst.pend", 32'(pending_any), 0);
      check("rst.ovf", 32'(overflow), 0);
      reset = 1'b0;
      cnt_p = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (out_pulse) begin
            if (cnt_p < 16) chs[cnt_p] = int'(out_ch);
            cnt_p++;
         end
      end
      check("rst.count", 32'(cnt_p), 4);
      for (int k = 0; k < 4; k++)
         check($sformatf("rst.order%0d", k), (k < cnt_p) ? 32'(chs[k]) : 32'hFF, 32'(k));

      // dst_ready gating: held low while ch 3 pending, then dropped during gap.
      lvl = '0; dst_ready = 1'b0;
      do_reset();
      lvl[3] = 1'b1; tick();
      lvl[3] = 1'b0; tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         check("rdy.hold", 32'(out_pulse), 0);
      end
      check("rdy.pend", 32'(pending_any), 1);
      dst_ready = 1'b1;
      tick();
      check("rdy.pulse1", 32'(out_pulse), 1);
      check("rdy.ch1", 32'(out_ch), 3);
      dst_ready = 1'b0;
      tick();
      check("rdy.one_cycle", 32'(out_pulse), 0);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("rdy.withheld", 32'(out_pulse), 0);
      end
      check("rdy.pend2", 32'(pending_any), 1);
      dst_ready = 1'b1;
      tick();
      check("rdy.pulse2", 32'(out_pulse), 1);
      check("rdy.ch2", 32'(out_ch), 3);
      check("rdy.pend_done", 32'(pending_any), 0);

      // Fairness: ch 0 toggles every cycle, ch 2 has a single event.
      lvl = '0; dst_ready = 1'b1;
      do_reset();
      cnt_p = 0;
      for (int c = 0; c < 20; c++) begin
         lvl[0] = ~lvl[0];
         if (c == 0) lvl[2] = 1'b1;
         tick();
         if (out_pulse) begin
            if (cnt_p < 16) chs[cnt_p] = int'(out_ch);
            cnt_p++;
         end
      end
      check("rr.count", 32'(cnt_p >= 3), 1);
      check("rr.first", (cnt_p > 0) ? 32'(chs[0]) : 32'hFF, 0);
      check("rr.second", (cnt_p > 1) ? 32'(chs[1]) : 32'hFF, 2);
      check("rr.third", (cnt_p > 2) ? 32'(chs[2]) : 32'hFF, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
